// File: rtl/md_unit_if.sv
// Decoder/E-stage side of the multiply/divide unit: opcode, operands, HI/LO read select and status.
interface md_unit_if;
   logic [2:0]  ALUMDctr;
   logic [31:0] A;
   logic [31:0] B;
   logic        LOHIsel;
   logic        IntReq;
   logic        Start;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDOut;

   modport master (
      output ALUMDctr, A, B, LOHIsel, IntReq,
      input  Start, Busy, HI, LO, MDOut
   );

   modport slave (
      input  ALUMDctr, A, B, LOHIsel, IntReq,
      output Start, Busy, HI, LO, MDOut
   );
endinterface

// File: rtl/md_unit.sv
// E-stage multiply/divide sequencer: computes the result on Start, then holds Busy for a fixed latency
// before committing it to HI/LO. Also serves mthi/mtlo writes and mfhi/mflo reads.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic      clk,
   input  logic      reset,
   md_unit_if.slave  md
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MTHI  = 3'd6;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

   state_e             state_q,  state_d;
   logic               busy_q,   busy_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [31:0]        hi_q,     hi_d;
   logic [31:0]        lo_q,     lo_d;
   logic [31:0]        hi_nxt_q, hi_nxt_d;
   logic [31:0]        lo_nxt_q, lo_nxt_d;

   logic               start_c;
   logic               is_md_op_c;
   logic               is_mult_c;
   logic [31:0]        res_hi_c;
   logic [31:0]        res_lo_c;

   logic signed [63:0] sa64, sb64, sprod;
   logic        [63:0] uprod;
   logic signed [31:0] sa32, sb32, squot, srem;
   logic        [31:0] uquot, urem;

   // Single-cycle arithmetic; the latency is modelled by the busy counter.
   always_comb begin
      sa64  = {{32{md.A[31]}}, md.A};
      sb64  = {{32{md.B[31]}}, md.B};
      sprod = sa64 * sb64;
      uprod = {32'd0, md.A} * {32'd0, md.B};
      sa32  = md.A;
      sb32  = md.B;
      squot = 32'sd0;
      srem  = 32'sd0;
      uquot = 32'd0;
      urem  = 32'd0;
      if (md.B != 32'd0) begin
         squot = sa32 / sb32;
         srem  = sa32 % sb32;
         uquot = md.A / md.B;
         urem  = md.A % md.B;
      end
      res_hi_c = 32'd0;
      res_lo_c = 32'd0;
      case (md.ALUMDctr)
         OP_MULT: begin
            res_hi_c = sprod[63:32];
            res_lo_c = sprod[31:0];
         end
         OP_MULTU: begin
            res_hi_c = uprod[63:32];
            res_lo_c = uprod[31:0];
         end
         OP_DIV: begin
            if (md.B == 32'd0) begin
               res_hi_c = md.A;
               res_lo_c = 32'hFFFF_FFFF;
            end else if (md.A == 32'h8000_0000 && md.B == 32'hFFFF_FFFF) begin
               res_hi_c = 32'd0;
               res_lo_c = 32'h8000_0000;
            end else begin
               res_hi_c = srem;
               res_lo_c = squot;
            end
         end
         OP_DIVU: begin
            if (md.B == 32'd0) begin
               res_hi_c = md.A;
               res_lo_c = 32'hFFFF_FFFF;
            end else begin
               res_hi_c = urem;
               res_lo_c = uquot;
            end
         end
         default: begin
            res_hi_c = 32'd0;
            res_lo_c = 32'd0;
         end
      endcase
   end

   assign is_md_op_c = (md.ALUMDctr >= OP_MULT) && (md.ALUMDctr <= OP_DIVU);
   assign is_mult_c  = (md.ALUMDctr == OP_MULT) || (md.ALUMDctr == OP_MULTU);
   assign start_c    = is_md_op_c && !md.IntReq && (state_q == S_IDLE);

   // Next-state logic; ops seen while busy are dropped by construction.
   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      hi_nxt_d = hi_nxt_q;
      lo_nxt_d = lo_nxt_q;
      case (state_q)
         S_IDLE: begin
            if (start_c) begin
               hi_nxt_d = res_hi_c;
               lo_nxt_d = res_lo_c;
               cnt_d    = is_mult_c ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
               busy_d   = 1'b1;
               state_d  = S_BUSY;
            end else if (!md.IntReq) begin
               if (md.ALUMDctr == OP_MTLO) lo_d = md.A;
               if (md.ALUMDctr == OP_MTHI) hi_d = md.A;
            end
         end
         S_BUSY: begin
            if (cnt_q == CNT_W'(0)) begin
               hi_d    = hi_nxt_q;
               lo_d    = lo_nxt_q;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         hi_nxt_q <= 32'd0;
         lo_nxt_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         hi_nxt_q <= hi_nxt_d;
         lo_nxt_q <= lo_nxt_d;
      end
   end

   assign md.Start = start_c;
   assign md.Busy  = busy_q;
   assign md.HI    = hi_q;
   assign md.LO    = lo_q;
   assign md.MDOut = md.LOHIsel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed-vector bench for md_unit: latency, arithmetic corner cases, mthi/mtlo, IntReq and reset abort.
module tb_md_unit;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_miss;

   md_unit_if md();

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (md.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      md.ALUMDctr = 3'd0;
      md.IntReq   = 1'b0;
   endtask

   // Issue one op, optionally inject mid_op/mid_irq at busy cycle mid_at, then check latency and result.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int mid_at, input logic [2:0] mid_op, input logic mid_irq);
      logic [31:0] lo_before;
      int cnt;
      lo_before   = md.LO;
      md.ALUMDctr = op;
      md.A        = a;
      md.B        = b;
      md.IntReq   = 1'b0;
      #1;
      check({tag, "_start"}, 32'(md.Start), 32'd1);
      tick();
      cnt = 0;
      while (md.Busy === 1'b1 && cnt < 50) begin
         if (cnt == mid_at) begin
            md.ALUMDctr = mid_op;
            md.A        = 32'hDEAD_BEEF;
            md.IntReq   = mid_irq;
            #1;
            check({tag, "_nostart"}, 32'(md.Start), 32'd0);
         end else begin
            idle_inputs();
         end
         if (mid_at >= 0 && cnt == mid_at + 1)
            check({tag, "_lo_hold"}, md.LO, lo_before);
         cnt++;
         tick();
      end
      idle_inputs();
      check({tag, "_busy_len"}, 32'(cnt), 32'(n));
      check({tag, "_hi"}, md.HI, exp_hi);
      check({tag, "_lo"}, md.LO, exp_lo);
   endtask

   initial begin
      int cnt;
      logic [31:0] hi_s, lo_s;
      n_vec       = 0;
      n_miss      = 0;
      reset       = 1'b1;
      md.ALUMDctr = 3'd0;
      md.A        = 32'd0;
      md.B        = 32'd0;
      md.LOHIsel  = 1'b0;
      md.IntReq   = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_busy", 32'(md.Busy), 32'd0);
      check("rst_hi", md.HI, 32'd0);
      check("rst_lo", md.LO, 32'd0);
      check("rst_mdout", md.MDOut, 32'd0);

      run_op("mult",  3'd1, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1, 3'd0, 1'b0);
      run_op("multu", 3'd2, 32'hFFFF_FFFD, 32'd7, 5, 32'h0000_0006, 32'hFFFF_FFEB, -1, 3'd0, 1'b0);
      run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, 3'd0, 1'b0);
      run_op("div_neg_divisor", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, -1, 3'd0, 1'b0);
      run_op("divu_by0", 3'd4, 32'd7, 32'd0, 10, 32'h0000_0007, 32'hFFFF_FFFF, -1, 3'd0, 1'b0);
      run_op("div_by0",  3'd3, 32'hFFFF_FFF9, 32'd0, 10, 32'hFFFF_FFF9, 32'hFFFF_FFFF, -1, 3'd0, 1'b0);
      run_op("div_ovf",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, -1, 3'd0, 1'b0);
      run_op("divu",  3'd4, 32'd100, 32'd7, 10, 32'h0000_0002, 32'h0000_000E, -1, 3'd0, 1'b0);

      // mthi / mtlo in IDLE and the MDOut read mux
      md.ALUMDctr = 3'd6;
      md.A        = 32'h1234_5678;
      tick();
      md.ALUMDctr = 3'd5;
      md.A        = 32'hAAAA_5555;
      md.LOHIsel  = 1'b1;
      #1;
      check("mthi_hi", md.HI, 32'h1234_5678);
      check("mthi_mdout", md.MDOut, 32'h1234_5678);
      tick();
      idle_inputs();
      md.LOHIsel = 1'b0;
      #1;
      check("mtlo_mdout", md.MDOut, 32'hAAAA_5555);
      check("mtlo_hi_kept", md.HI, 32'h1234_5678);

      // reserved opcode has no effect
      md.ALUMDctr = 3'd7;
      #1;
      check("rsvd_start", 32'(md.Start), 32'd0);
      tick();
      idle_inputs();
      check("rsvd_busy", 32'(md.Busy), 32'd0);
      check("rsvd_lo", md.LO, 32'hAAAA_5555);

      // IntReq coincident with mult and with mthi suppresses both
      md.ALUMDctr = 3'd1;
      md.A        = 32'd3;
      md.B        = 32'd5;
      md.IntReq   = 1'b1;
      #1;
      check("irq_start", 32'(md.Start), 32'd0);
      tick();
      md.ALUMDctr = 3'd6;
      md.A        = 32'h0BAD_0BAD;
      tick();
      idle_inputs();
      check("irq_busy", 32'(md.Busy), 32'd0);
      check("irq_hi", md.HI, 32'h1234_5678);
      check("irq_lo", md.LO, 32'hAAAA_5555);

      // IntReq while busy does not abort; mtlo while busy is ignored
      run_op("mult_irq_busy", 3'd1, 32'd3, 32'd5, 5, 32'd0, 32'd15, 1, 3'd0, 1'b1);
      run_op("mult_mtlo_busy", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'd0, 32'd1, 1, 3'd5, 1'b0);

      // Reset during busy cycle 3 aborts and leaves no late write
      md.ALUMDctr = 3'd1;
      md.A        = 32'h0001_0000;
      md.B        = 32'h0003_0000;
      tick();
      idle_inputs();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rstmid_busy", 32'(md.Busy), 32'd0);
      check("rstmid_hi", md.HI, 32'd0);
      check("rstmid_lo", md.LO, 32'd0);
      repeat (8) tick();
      check("rstmid_late_hi", md.HI, 32'd0);
      check("rstmid_late_lo", md.LO, 32'd0);
      check("rstmid_late_busy", 32'(md.Busy), 32'd0);

      // Back-to-back: divu held during mult busy starts in the first idle cycle
      md.ALUMDctr = 3'd1;
      md.A        = 32'd2;
      md.B        = 32'd3;
      #1;
      check("b2b_start1", 32'(md.Start), 32'd1);
      tick();
      md.ALUMDctr = 3'd4;
      md.A        = 32'd100;
      md.B        = 32'd7;
      cnt = 0;
      while (md.Busy === 1'b1 && cnt < 50) begin
         if (cnt == 0) check("b2b_held_nostart", 32'(md.Start), 32'd0);
         cnt++;
         tick();
      end
      check("b2b_mult_len", 32'(cnt), 32'd5);
      hi_s = md.HI;
      lo_s = md.LO;
      check("b2b_mult_hi", hi_s, 32'd0);
      check("b2b_mult_lo", lo_s, 32'd6);
      check("b2b_start2", 32'(md.Start), 32'd1);
      tick();
      idle_inputs();
      cnt = 0;
      while (md.Busy === 1'b1 && cnt < 50) begin
         cnt++;
         tick();
      end
      check("b2b_divu_len", 32'(cnt), 32'd10);
      check("b2b_divu_hi", md.HI, 32'd2);
      check("b2b_divu_lo", md.LO, 32'd14);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
